sipo_deframer: RTL and testbench

Serial-to-parallel receive stage that sits directly downstream of the team's 4-bit parallel-in/serial-out shifter. It samples the MSB-first serial stream one qualified bit at a time and reassembles WIDTH-bit words aligned to a frame-start strobe. Completed words are presented through a registered valid/ready output buffer, with a sticky overrun flag for words that cannot be delivered.

---
 rtl/sipo_deframer.sv | 120 ++++++++++++
 tb/tb_sipo_deframer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deframer.sv
// ---------------------------------------------------------------------------
// sipo_deframer
// Serial-to-parallel receive stage. It takes an MSB-first serial stream, one
// qualified bit per bit_valid edge, and rebuilds WIDTH-bit words that line up
// with a frame-start strobe. Each finished word goes into a one-entry
// valid/ready output buffer. If a word finishes while that buffer is still
// full, the word is dropped and the sticky overrun flag is set.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        frame-start strobe, only meaningful when bit_valid=1
//   bit_valid    serial_in is sampled on this edge
//   serial_in    serial data, MSB first
//   out_ready    consumer takes the buffered word on this edge
//   parallel_out assembled word, held stable while out_valid=1
//   out_valid    parallel_out holds a word not yet delivered
//   busy         a frame is partially received
//   overrun      sticky, a completed word was dropped (cleared by reset only)
// ---------------------------------------------------------------------------
module sipo_deframer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             bit_valid,
   input  logic             serial_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-2:0] sh;
   logic [CW-1:0]    count;

   logic             completion;
   logic             buf_free;
   logic [WIDTH-1:0] word;

   // The shift register holds only the WIDTH-1 bits collected so far. The
   // final bit arrives on serial_in at the completion edge and is joined to
   // them there, so no register bit is ever unused.
   assign word       = {sh, serial_in};
   assign completion = (state == SHIFT) && bit_valid && !start &&
                       (count == CW'(WIDTH - 1));
   assign buf_free   = !out_valid || out_ready;

   // busy comes straight from the state register, so it has no path from
   // any input.
   assign busy = (state == SHIFT);

   // Frame assembly and the output buffer are kept in one block.
   // In both IDLE and SHIFT, a start bit places serial_in at bit 0 of sh.
   // After WIDTH-2 further shifts it reaches the top of sh, which makes it
   // the MSB of the finished word. A start seen in SHIFT discards the
   // partial word and restarts the frame. At completion the word goes into
   // the buffer if the buffer is empty or being emptied on this same edge.
   // Otherwise the word is dropped and overrun is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sh           <= '0;
         count        <= '0;
         parallel_out <= '0;
         out_valid    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bit_valid && start) begin
                  sh    <= (WIDTH-1)'(serial_in);
                  count <= CW'(1);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_valid) begin
                  if (start) begin
                     sh    <= (WIDTH-1)'(serial_in);
                     count <= CW'(1);
                  end else if (completion) begin
                     count <= '0;
                     state <= IDLE;
                  end else begin
                     sh    <= word[WIDTH-2:0];
                     count <= count + CW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase

         if (completion) begin
            if (buf_free) begin
               parallel_out <= word;
               out_valid    <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_deframer.sv
// ---------------------------------------------------------------------------
// tb_sipo_deframer
// Self-checking bench for sipo_deframer with WIDTH=4.
//
// The reference model works at the frame level. It gathers qualified bits
// into a queue, packs the queue into a number once it holds WIDTH bits, and
// then applies the delivery rules to a one-entry buffer. After every clock
// edge, all DUT outputs are compared against this model. The bench runs the
// directed scenarios first and then a block of randomized traffic.
// ---------------------------------------------------------------------------
module tb_sipo_deframer;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         bit_valid;
   logic         serial_in;
   logic         out_ready;
   logic [W-1:0] parallel_out;
   logic         out_valid;
   logic         busy;
   logic         overrun;

   int tests_run;
   int tests_failed;

   // Reference model state
   bit           m_bits[$];
   bit           m_in_frame;
   logic [W-1:0] m_data;
   bit           m_valid;
   bit           m_ovr;
   int           m_words;

   sipo_deframer #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .bit_valid    (bit_valid),
      .serial_in    (serial_in),
      .out_ready    (out_ready),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   // Free-running clock with a 10-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison in the bench goes through this task
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      m_bits.delete();
      m_in_frame = 0;
      m_data     = '0;
      m_valid    = 0;
      m_ovr      = 0;
   endtask

   // Frame-level reference model, advanced once per clock edge
   task automatic modelStep(input bit st, input bit bv, input bit si,
                            input bit rdy);
      bit           done;
      logic [W-1:0] w;
      done = 0;
      w    = '0;
      if (bv) begin
         if (st) begin
            m_bits.delete();
            m_bits.push_back(si);
            m_in_frame = 1;
         end else if (m_in_frame) begin
            m_bits.push_back(si);
            if (m_bits.size() == W) begin
               foreach (m_bits[i]) w = W'((w << 1) | W'(m_bits[i]));
               m_bits.delete();
               m_in_frame = 0;
               done       = 1;
            end
         end
      end
      if (done) begin
         m_words++;
         if (!m_valid || rdy) begin
            m_data  = w;
            m_valid = 1;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".parallel_out"}, 32'(parallel_out), 32'(m_data));
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(m_in_frame));
      checkOutput({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
   endtask

   // Drive one cycle of inputs while the clock is low, step the model on
   // the rising edge, and compare just after that edge.
   task automatic applyStimulus(input bit st, input bit bv, input bit si,
                                input bit rdy, input string tag);
      start     = st;
      bit_valid = bv;
      serial_in = si;
      out_ready = rdy;
      @(posedge clk);
      modelStep(st, bv, si, rdy);
      #1;
      checkAll(tag);
   endtask

   // Send one word MSB first with start on the first bit. Idle cycles of
   // length gap separate the bits. out_ready is rdy on every cycle except
   // the completion edge, which uses rdy_last.
   task automatic sendWord(input logic [W-1:0] w, input int gap,
                           input bit rdy, input bit rdy_last,
                           input string tag);
      logic [W-1:0] tmp;
      tmp = w;
      for (int i = W - 1; i >= 0; i--) begin
         applyStimulus(i == W - 1, 1'b1, tmp[i], (i == 0) ? rdy_last : rdy,
                       tag);
         if (i != 0)
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0, rdy, tag);
      end
   endtask

   // Assert reset between clock edges and confirm that the outputs clear
   // at once, without waiting for an edge.
   task automatic midCycleReset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput({tag, ".parallel_out"}, 32'(parallel_out), 32'h0);
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'h0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
      checkOutput({tag, ".overrun"}, 32'(overrun), 32'h0);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int ovr_base;
      int start_words;
      tests_run    = 0;
      tests_failed = 0;
      m_words      = 0;
      modelReset();
      rst_n     = 1'b0;
      start     = 1'b0;
      bit_valid = 1'b0;
      serial_in = 1'b0;
      out_ready = 1'b0;
      #12;
      checkAll("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset in the middle of a frame, then send bits without start
      applyStimulus(1, 1, 1, 0, "pre_reset");
      applyStimulus(0, 1, 0, 0, "pre_reset");
      midCycleReset("mid_reset");
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, i[0], 0, "no_start");
      checkOutput("no_start.busy_idle", 32'(busy), 32'h0);

      // Basic back-to-back frame: 1,0,1,1
      sendWord(4'b1011, 0, 0, 0, "basic");
      checkOutput("basic.word", 32'(parallel_out), 32'hB);
      checkOutput("basic.valid", 32'(out_valid), 32'h1);
      applyStimulus(0, 0, 0, 1, "drain");

      // Same word with two idle cycles between bits
      sendWord(4'b1011, 2, 0, 0, "gapped");
      checkOutput("gapped.word", 32'(parallel_out), 32'hB);
      applyStimulus(0, 0, 0, 1, "drain");

      // Overrun: the second word is dropped and the first is kept
      sendWord(4'b1011, 0, 0, 0, "ovr_first");
      sendWord(4'b0110, 0, 0, 0, "ovr_second");
      checkOutput("overrun.word", 32'(parallel_out), 32'hB);
      checkOutput("overrun.flag", 32'(overrun), 32'h1);
      applyStimulus(0, 0, 0, 1, "ovr_accept");
      checkOutput("overrun.valid_cleared", 32'(out_valid), 32'h0);
      checkOutput("overrun.sticky", 32'(overrun), 32'h1);

      midCycleReset("reset2");
      @(posedge clk);
      #1;

      // Accept on completion: the new word replaces the old one on one edge
      sendWord(4'b1011, 0, 0, 0, "aoc_first");
      sendWord(4'b0110, 0, 0, 1, "aoc_second");
      checkOutput("aoc.word", 32'(parallel_out), 32'h6);
      checkOutput("aoc.valid", 32'(out_valid), 32'h1);
      checkOutput("aoc.overrun", 32'(overrun), 32'h0);
      applyStimulus(0, 0, 0, 1, "drain");

      // Resync: a partial frame is discarded and a single word follows
      start_words = m_words;
      applyStimulus(1, 1, 1, 0, "resync");
      applyStimulus(0, 1, 1, 0, "resync");
      sendWord(4'b0101, 0, 0, 0, "resync");
      applyStimulus(0, 0, 0, 0, "resync_idle");
      checkOutput("resync.word", 32'(parallel_out), 32'h5);
      checkOutput("resync.one_word", 32'(m_words - start_words), 32'h1);
      checkOutput("resync.no_overrun", 32'(overrun), 32'h0);
      applyStimulus(0, 0, 0, 1, "drain");

      // Randomized traffic against the model
      ovr_base = 0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) midCycleReset("rand_reset");
         applyStimulus($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 75,
                       1'($urandom), $urandom_range(0, 99) < 50, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
